// File: rtl/mem_arb_pkg.sv
// Shared types and requester ids for the two-port memory arbiter.
package mem_arb_pkg;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef struct packed {
        logic                  we;
        logic [ARB_AW-1:0]     addr;
        logic [ARB_DW-1:0]     wdata;
        logic [ARB_DW/8-1:0]   wm;
    } mem_req_t;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter: two request channels, two response strobes, shared read data.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]                rq_valid;
    logic [1:0]                rq_ready;
    logic [1:0]                rq_we;
    logic [1:0][AW-1:0]        rq_addr;
    logic [1:0][DW-1:0]        rq_wdata;
    logic [1:0][DW/8-1:0]      rq_wm;
    logic [1:0]                rs_valid;
    logic [DW-1:0]             rs_rdata;

    modport master (
        output rq_valid, rq_we, rq_addr, rq_wdata, rq_wm,
        input  rq_ready, rs_valid, rs_rdata
    );

    modport slave (
        input  rq_valid, rq_we, rq_addr, rq_wdata, rq_wm,
        output rq_ready, rs_valid, rs_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant remembers the previous winner so a conflict goes to the other side.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       grant_id,
    output logic       granted
);

    logic last_grant;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        grant    = 2'b00;
        grant_id = REQ_CPU;
        case (valid)
            2'b01: grant_id = REQ_CPU;
            2'b10: grant_id = REQ_DMA;
            2'b11: grant_id = ~last_grant;
            default: grant_id = REQ_CPU;
        endcase
        granted = |valid;
        if (granted) grant = grant_id ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= REQ_DMA;
        end else if (granted) begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the RAM regular port between CPU and DMA requesters and returns each response RD_LAT cycles later.
// Optional perf counters are compiled in with `define MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              mem_we,
    output logic [AW-1:0]     mem_a,
    output logic [DW-1:0]     mem_wd,
    output logic [DW/8-1:0]   mem_wm,
    input  logic [DW-1:0]     mem_rd
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_conflict
`endif
);

    logic [1:0] grant;
    logic       grant_id;
    logic       granted;
    tag_t       tag_q [RD_LAT];
    tag_t       tag_out;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .valid    (bus.rq_valid),
        .grant    (grant),
        .grant_id (grant_id),
        .granted  (granted)
    );

    assign bus.rq_ready = grant;

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        mem_wm = '0;
        if (granted) begin
            mem_a  = bus.rq_addr[grant_id];
            mem_wd = bus.rq_wdata[grant_id];
            mem_wm = bus.rq_wm[grant_id];
            // A zero-mask write is acknowledged but must not touch the RAM.
            mem_we = bus.rq_we[grant_id] && (|bus.rq_wm[grant_id]);
        end
    end

    // NOTE: the tag pipeline is control state and is reset so in-flight responses are dropped; the RAM itself is not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: granted, id: grant_id};
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[RD_LAT-1];

    always_comb begin
        bus.rs_valid = 2'b00;
        if (tag_out.valid) bus.rs_valid = (tag_out.id == REQ_DMA) ? 2'b10 : 2'b01;
        bus.rs_rdata = (|bus.rs_valid) ? mem_rd : '0;
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant[0]) perf_grant0 <= perf_grant0 + 32'd1;
            if (grant[1]) perf_grant1 <= perf_grant1 + 32'd1;
            if (&bus.rq_valid) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at RD_LAT=1 and one at RD_LAT=3, each with a behavioural read-before-write RAM.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset1, reset3;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    logic        mem_we1, mem_we3;
    logic [31:0] mem_a1, mem_a3, mem_wd1, mem_wd3, mem_rd1, mem_rd3;
    logic [3:0]  mem_wm1, mem_wm3;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] pg0_1, pg1_1, pc_1, pg0_3, pg1_3, pc_3;
`endif

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset1), .bus(bus1),
        .mem_we(mem_we1), .mem_a(mem_a1), .mem_wd(mem_wd1), .mem_wm(mem_wm1), .mem_rd(mem_rd1)
`ifdef MEM_ARB_PERF_EN
        , .perf_grant0(pg0_1), .perf_grant1(pg1_1), .perf_conflict(pc_1)
`endif
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset3), .bus(bus3),
        .mem_we(mem_we3), .mem_a(mem_a3), .mem_wd(mem_wd3), .mem_wm(mem_wm3), .mem_rd(mem_rd3)
`ifdef MEM_ARB_PERF_EN
        , .perf_grant0(pg0_3), .perf_grant1(pg1_3), .perf_conflict(pc_3)
`endif
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
    endfunction

    // RAM models: read-before-write, data appears RD_LAT edges after the address.
    logic [31:0] ram1 [256];
    logic [31:0] ram3 [256];
    logic [31:0] rd1;
    logic [31:0] rd3 [3];

    always @(posedge clk or posedge reset1) begin
        if (reset1) begin
            for (int i = 0; i < 256; i++) ram1[i] <= init_word(i);
            rd1 <= '0;
        end else begin
            rd1 <= ram1[mem_a1[9:2]];
            if (mem_we1)
                for (int b = 0; b < 4; b++)
                    if (mem_wm1[b]) ram1[mem_a1[9:2]][8*b +: 8] <= mem_wd1[8*b +: 8];
        end
    end
    assign mem_rd1 = rd1;

    always @(posedge clk or posedge reset3) begin
        if (reset3) begin
            for (int i = 0; i < 256; i++) ram3[i] <= init_word(i);
            for (int j = 0; j < 3; j++) rd3[j] <= '0;
        end else begin
            rd3[0] <= ram3[mem_a3[9:2]];
            rd3[1] <= rd3[0];
            rd3[2] <= rd3[1];
            if (mem_we3)
                for (int b = 0; b < 4; b++)
                    if (mem_wm3[b]) ram3[mem_a3[9:2]][8*b +: 8] <= mem_wd3[8*b +: 8];
        end
    end
    assign mem_rd3 = rd3[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic mem_req_t rd(input logic [31:0] a);
        return '{we: 1'b0, addr: a, wdata: 32'h0, wm: 4'h0};
    endfunction

    function automatic mem_req_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        return '{we: 1'b1, addr: a, wdata: d, wm: m};
    endfunction

    task automatic set1(input logic [1:0] v, input mem_req_t r0, input mem_req_t r1);
        bus1.rq_valid = v;
        bus1.rq_we    = {r1.we, r0.we};
        bus1.rq_addr  = {r1.addr, r0.addr};
        bus1.rq_wdata = {r1.wdata, r0.wdata};
        bus1.rq_wm    = {r1.wm, r0.wm};
    endtask

    task automatic set3(input logic [1:0] v, input mem_req_t r0, input mem_req_t r1);
        bus3.rq_valid = v;
        bus3.rq_we    = {r1.we, r0.we};
        bus3.rq_addr  = {r1.addr, r0.addr};
        bus3.rq_wdata = {r1.wdata, r0.wdata};
        bus3.rq_wm    = {r1.wm, r0.wm};
    endtask

    initial begin
        reset1 = 1'b1;
        reset3 = 1'b1;
        set1(2'b00, rd(0), rd(0));
        set3(2'b00, rd(0), rd(0));
        repeat (2) @(negedge clk);
        #1;
        check("rst_rs_valid", 64'(bus1.rs_valid), 64'h0);
        check("rst_rs_rdata", 64'(bus1.rs_rdata), 64'h0);
        check("rst_ready",    64'(bus1.rq_ready), 64'h0);
        check("rst_mem_we",   64'(mem_we1), 64'h0);
        check("rst_mem_a",    64'(mem_a1), 64'h0);
        check("rst3_rs_valid", 64'(bus3.rs_valid), 64'h0);
        reset1 = 1'b0;
        reset3 = 1'b0;

        // Single read by requester 0
        @(negedge clk); set1(2'b01, rd(32'h10), rd(0)); #1;
        check("rd0_ready", 64'(bus1.rq_ready), 64'h1);
        check("rd0_mem_a", 64'(mem_a1), 64'h10);
        check("rd0_mem_we", 64'(mem_we1), 64'h0);
        check("rd0_no_early_rs", 64'(bus1.rs_valid), 64'h0);

        // Zero-mask write by requester 0: accepted, no RAM write
        @(negedge clk); set1(2'b01, wr(32'h40, 32'hFFFFFFFF, 4'h0), rd(0)); #1;
        check("rd0_rs_valid", 64'(bus1.rs_valid), 64'h1);
        check("rd0_rs_rdata", 64'(bus1.rs_rdata), 64'hDEADBEEF);
        check("wm0_ready", 64'(bus1.rq_ready), 64'h1);
        check("wm0_mem_we", 64'(mem_we1), 64'h0);

        // Byte write by requester 1
        @(negedge clk); set1(2'b10, rd(0), wr(32'h20, 32'h11223344, 4'b0100)); #1;
        check("wm0_rs_valid", 64'(bus1.rs_valid), 64'h1);
        check("bw_ready", 64'(bus1.rq_ready), 64'h2);
        check("bw_mem_we", 64'(mem_we1), 64'h1);
        check("bw_mem_wm", 64'(mem_wm1), 64'h4);
        check("bw_mem_wd", 64'(mem_wd1), 64'h11223344);
        check("bw_mem_a", 64'(mem_a1), 64'h20);

        // Read-back by requester 1
        @(negedge clk); set1(2'b10, rd(0), rd(32'h20)); #1;
        check("bw_rs_valid", 64'(bus1.rs_valid), 64'h2);
        check("bw_old_word", 64'(bus1.rs_rdata), 64'hC0DE0008);
        check("rb_ready", 64'(bus1.rq_ready), 64'h2);

        // Sustained conflict: requester 0 reads 0x0, requester 1 reads 0x4
        @(negedge clk); set1(2'b11, rd(32'h0), rd(32'h4)); #1;
        check("rb_rs_valid", 64'(bus1.rs_valid), 64'h2);
        check("rb_rs_rdata", 64'(bus1.rs_rdata), 64'hC0220008);
        check("cf_ready_0", 64'(bus1.rq_ready), 64'h1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 6) set1(2'b00, rd(0), rd(0));
            #1;
            check($sformatf("cf_ready_%0d", i), 64'(bus1.rq_ready),
                  (i == 6) ? 64'h0 : ((i % 2 == 0) ? 64'h1 : 64'h2));
            check($sformatf("cf_rs_valid_%0d", i), 64'(bus1.rs_valid),
                  ((i - 1) % 2 == 0) ? 64'h1 : 64'h2);
            check($sformatf("cf_rs_rdata_%0d", i), 64'(bus1.rs_rdata),
                  ((i - 1) % 2 == 0) ? 64'hC0DE0000 : 64'hC0DE0001);
        end
        @(negedge clk); #1;
        check("idle_rs_valid", 64'(bus1.rs_valid), 64'h0);
        check("idle_rs_rdata", 64'(bus1.rs_rdata), 64'h0);
        check("idle_mem_a", 64'(mem_a1), 64'h0);

        // RD_LAT=3: eight back-to-back reads by requester 0
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 8) set3(2'b01, rd(32'(4 * k)), rd(0));
            else       set3(2'b00, rd(0), rd(0));
            #1;
            check($sformatf("l3_ready_%0d", k), 64'(bus3.rq_ready), (k < 8) ? 64'h1 : 64'h0);
            check($sformatf("l3_rs_valid_%0d", k), 64'(bus3.rs_valid),
                  (k >= 3 && k < 11) ? 64'h1 : 64'h0);
            if (k >= 3 && k < 11)
                check($sformatf("l3_rs_rdata_%0d", k), 64'(bus3.rs_rdata), 64'(init_word(k - 3)));
        end

        // Reset one cycle after a granted read: response discarded, last_grant back to 1
        @(negedge clk); set3(2'b01, rd(32'h10), rd(0)); #1;
        check("rr_ready", 64'(bus3.rq_ready), 64'h1);
        check("rr_mem_a", 64'(mem_a3), 64'h10);
        @(negedge clk); set3(2'b00, rd(0), rd(0)); reset3 = 1'b1; #1;
        check("rr_rs_in_reset", 64'(bus3.rs_valid), 64'h0);
        @(negedge clk); reset3 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check($sformatf("rr_no_rs_%0d", j), 64'(bus3.rs_valid), 64'h0);
            @(negedge clk);
        end
        set3(2'b11, rd(32'h0), rd(32'h4)); #1;
        check("rr_first_conflict", 64'(bus3.rq_ready), 64'h1);
        @(negedge clk); set3(2'b00, rd(0), rd(0));

`ifdef MEM_ARB_PERF_EN
        @(negedge clk); reset1 = 1'b1; #1;
        check("perf_rst_g0", 64'(pg0_1), 64'h0);
        check("perf_rst_g1", 64'(pg1_1), 64'h0);
        check("perf_rst_cf", 64'(pc_1), 64'h0);
        @(negedge clk); reset1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) set1(2'b11, rd(32'h0), rd(32'h4));
            else       set1(2'b10, rd(0), rd(32'h8));
            @(negedge clk);
        end
        set1(2'b00, rd(0), rd(0)); #1;
        check("perf_grant0", 64'(pg0_1), 64'd3);
        check("perf_grant1", 64'(pg1_1), 64'd5);
        check("perf_conflict", 64'(pc_1), 64'd5);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single read/write port of the unified instruction/data RAM between two requesters: requester 0 (CPU data access) and requester 1 (loader/DMA engine).
- Round-robin arbitration on conflict; at most one memory access per cycle.
- Tracks in-flight accesses through the RAM's fixed synchronous read latency and routes each response back to its issuer.
- Sits between the requesters and the RAM regular port; the RAM video port is not touched.

Parameters:
- AW, 32, byte-address width.
- DW, 32, data width; byte mask width is DW/8.
- RD_LAT, 1, RAM read latency in cycles (posedge address to rd valid); legal range 1..4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- rq_valid  in  2  per-requester request valid (bit i = requester i)
- rq_ready  out  2  per-requester accept; a transfer occurs when valid&ready
- rq_we  in  2  per-requester write enable
- rq_addr  in  2xAW  per-requester byte address
- rq_wdata  in  2xDW  per-requester write data
- rq_wm  in  2x(DW/8)  per-requester byte write mask
- rs_valid  out  2  per-requester response strobe
- rs_rdata  out  DW  read data, shared; qualified by rs_valid
- mem_we  out  1  to RAM we
- mem_a  out  AW  to RAM a
- mem_wd  out  DW  to RAM wd
- mem_wm  out  DW/8  to RAM wm
- mem_rd  in  DW  from RAM rd

Behaviour:
- Arbitration is combinational in the request cycle.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester opposite to last_grant.
  - Neither valid: no grant.
- rq_ready = grant vector (one-hot or zero); ready may depend on valid.
- last_grant register updates only on a granted cycle. Reset value 1, so requester 0 wins the first conflict.
- Granted cycle: mem_a/mem_wd/mem_wm/mem_we driven from the granted requester's inputs the same cycle.
- Non-granted cycle: mem_we=0, mem_wm=0, mem_a=0, mem_wd=0.
- mem_we is asserted only when the granted request has rq_we=1 and a nonzero rq_wm. A write with rq_wm=0 is still accepted and acknowledged but drives mem_we=0.
- Tag pipeline has RD_LAT stages. Each stage holds {valid, id} and shifts every cycle; stage 0 is loaded with {granted, grant_id}.
- Every accepted request, read or write, produces exactly one rs_valid[id] pulse exactly RD_LAT cycles after acceptance.
- rs_rdata = mem_rd whenever any rs_valid bit is high, else 0. For writes, rs_rdata carries the RAM's read-before-write word and is don't-care to the requester.
- Back-to-back acceptance is allowed every cycle; throughput is 1 access/cycle, fully pipelined, no stalls.
- Requester 1 sustaining valid cannot starve requester 0 (and vice versa): maximum wait under contention is 1 cycle.
- A request held valid but not granted must keep its fields stable; the arbiter does not latch ungranted requests.
- Reset (async, any time) forces:
  - last_grant=1
  - all tag stages invalid
  - rs_valid=0
  - perf counters 0
- In-flight responses at reset are discarded, never delivered.
- Read-after-write to the same address in consecutive cycles returns the old word (RAM semantics); requesters are responsible for ordering.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds outputs perf_grant0, perf_grant1 (32 bits, accepted requests per requester) and perf_conflict (32 bits, cycles with both valid). All counters wrap modulo 2^32, reset to 0, and increment in the accepting cycle.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - REQ_CPU=0 and REQ_DMA=1 id constants
  - typedef mem_req_t {we, addr, wdata, wm}
  - typedef tag_t {valid, id}
- One sub-module, rr_arb2: the 2-way round-robin grant plus the last_grant register. The tag pipeline and mux stay in the top.

Test Plan:
- Single read: req0 read addr 0x10 (RAM[4]=0xDEADBEEF) → rq_ready=01 that cycle, rs_valid=01 exactly RD_LAT cycles later, rs_rdata=0xDEADBEEF.
- Byte write: req1 write addr 0x20, wdata 0x11223344, wm=0100, then req1 read 0x20 → read returns the old word with byte 2 replaced by 0x22; rs_valid=10 for both.
- Sustained conflict: both valid for 6 cycles → grants 0,1,0,1,0,1; rs_valid alternates 01/10 starting RD_LAT cycles after the first grant.
- Fixed latency: repeat the single-read test with RD_LAT=3 → rs_valid appears exactly 3 cycles after acceptance for 8 back-to-back reads, in issue order.
- Reset mid-flight: assert reset one cycle after a granted read → no rs_valid after reset; next conflict grants requester 0.
- MEM_ARB_PERF_EN defined: 5 conflict cycles plus 3 solo req1 cycles → perf_grant0=3, perf_grant1=5, perf_conflict=5.
